// File: rtl/mem_node_responder.sv
// -----------------------------------------------------------------------------
// mem_node_responder
//
// Memory-side NoC endpoint. Reassembles 4-flit dmem request packets (one
// reassembly slot per source node), serves completed requests round-robin on
// a single-port SRAM, and returns a 2-flit response packet {resp, rdata} to
// the requesting node.
//
// Flit layout, MSB to LSB:
//   valid[1] src[NW] dest[NW] packet_id[PACKET_ID_WIDTH] seq[2] payload[17]
// Request packet (68 bits): {cmd, width[1:0], addr[31:0], wdata[31:0], pad}
// Response packet (34 bits): {resp[1:0], rdata[31:0]}
// Flit seq k carries packet bits [top-17k -: 17].
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flit_in         incoming flit from the router local port
//   flit_in_ready   flit_in is consumed when valid & ready
//   flit_out        outgoing response flit (MSB = valid)
//   flit_out_ready  router accepts flit_out this cycle
//   mem_req/we/be/addr/wdata   SRAM request, held stable until mem_ack
//   mem_ack/rdata/err          SRAM completion
//   drop_count      saturating count of discarded flits
//   busy            FSM not idle, or any slot holds a complete packet
// -----------------------------------------------------------------------------
module mem_node_responder #(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int MEM_AWIDTH      = 32,
    localparam int NW = $clog2(NODE_COUNT),
    localparam int FW = 1 + 2*NW + 17 + PACKET_ID_WIDTH + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FW-1:0]         flit_in,
    output logic                  flit_in_ready,
    output logic [FW-1:0]         flit_out,
    input  logic                  flit_out_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_err,
    output logic [7:0]            drop_count,
    output logic                  busy
);

    localparam int PIW      = PACKET_ID_WIDTH;
    localparam int SEQ_LSB  = 17;
    localparam int PID_LSB  = SEQ_LSB + 2;
    localparam int DEST_LSB = PID_LSB + PIW;
    localparam int SRC_LSB  = DEST_LSB + NW;

    localparam logic [1:0] RESP_OK  = 2'b01;
    localparam logic [1:0] RESP_ERR = 2'b10;

    typedef enum logic [1:0] {IDLE, MEM, RESP0, RESP1} state_t;

    // ---------------------------------------------------------------- input
    logic          in_valid;
    logic [NW-1:0] in_src;
    logic [NW-1:0] in_dest;
    logic [PIW-1:0] in_pid;
    logic [1:0]    in_seq;
    logic [16:0]   in_payload;
    logic          src_ok;
    logic          dest_ok;
    logic [NW-1:0] slot_idx;
    logic          accept;
    logic          seq_bad;
    logic          drop_event;

    // Slot storage keeps the 67 meaningful request bits; the pad bit is dropped.
    logic [66:0]          slot_data [NODE_COUNT];
    logic [PIW-1:0]       slot_pid  [NODE_COUNT];
    logic [1:0]           slot_exp  [NODE_COUNT];
    logic [NODE_COUNT-1:0] slot_complete;

    // ---------------------------------------------------------------- FSM regs
    state_t        state;
    logic [NW-1:0] rr_ptr;
    logic [NW-1:0] cur_src;
    logic [PIW-1:0] cur_pid;
    logic [1:0]    cur_shift;
    logic [16:0]   resp_lo;
    logic          release_slot;

    assign in_valid   = flit_in[FW-1];
    assign in_src     = flit_in[SRC_LSB +: NW];
    assign in_dest    = flit_in[DEST_LSB +: NW];
    assign in_pid     = flit_in[PID_LSB +: PIW];
    assign in_seq     = flit_in[SEQ_LSB +: 2];
    assign in_payload = flit_in[16:0];

    // Source IDs beyond NODE_COUNT have no slot; they are accepted and dropped.
    assign src_ok   = int'(in_src) < NODE_COUNT;
    assign dest_ok  = (in_dest == NW'(NODE_ID));
    assign slot_idx = src_ok ? in_src : '0;

    assign flit_in_ready = src_ok ? !slot_complete[slot_idx] : 1'b1;
    assign accept        = in_valid && flit_in_ready;

    // seq 0 always restarts a slot; any other out-of-order seq is a drop.
    assign seq_bad    = (in_seq != 2'd0) && (in_seq != slot_exp[slot_idx]);
    assign drop_event = accept && (!src_ok || !dest_ok || seq_bad);

    assign release_slot = (state == RESP1) && flit_out_ready;

    // ---------------------------------------------------------------- slot control
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_complete <= '0;
            drop_count    <= '0;
            for (int s = 0; s < NODE_COUNT; s++) begin
                slot_exp[s] <= 2'd0;
            end
        end else begin
            if (release_slot) begin
                slot_complete[cur_src] <= 1'b0;
            end
            if (drop_event && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (accept && src_ok && dest_ok) begin
                if (in_seq == 2'd0) begin
                    slot_exp[slot_idx] <= 2'd1;
                end else if (!seq_bad) begin
                    if (in_seq == 2'd3) begin
                        slot_exp[slot_idx]      <= 2'd0;
                        slot_complete[slot_idx] <= 1'b1;
                    end else begin
                        slot_exp[slot_idx] <= in_seq + 2'd1;
                    end
                end else begin
                    slot_exp[slot_idx] <= 2'd0;
                end
            end
        end
    end

    // NOTE: the slot payload array is not reset; it is only read once the
    // complete flag (which is reset) shows all four flits have been written.
    always_ff @(posedge clk) begin
        if (accept && src_ok && dest_ok && (in_seq == 2'd0 || !seq_bad)) begin
            case (in_seq)
                2'd0: begin
                    slot_data[slot_idx][66:50] <= in_payload;
                    slot_pid[slot_idx]         <= in_pid;
                end
                2'd1:    slot_data[slot_idx][49:33] <= in_payload;
                2'd2:    slot_data[slot_idx][32:16] <= in_payload;
                default: slot_data[slot_idx][15:0]  <= in_payload[16:1];
            endcase
        end
    end

    // ---------------------------------------------------------------- arbitration
    logic          pick_valid;
    logic [NW-1:0] pick_idx;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned, which would infer a latch.
    always_comb begin
        int j;
        pick_valid = 1'b0;
        pick_idx   = '0;
        // Walk from farthest to nearest so the slot closest after rr_ptr wins.
        for (int i = NODE_COUNT; i >= 1; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NODE_COUNT) begin
                j = j - NODE_COUNT;
            end
            if (slot_complete[j]) begin
                pick_valid = 1'b1;
                pick_idx   = NW'(j);
            end
        end
    end

    // ---------------------------------------------------------------- request decode
    logic        p_cmd;
    logic [1:0]  p_width;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_misaligned;
    logic [3:0]  p_be;

    assign p_cmd   = slot_data[pick_idx][66];
    assign p_width = slot_data[pick_idx][65:64];
    assign p_addr  = slot_data[pick_idx][63:32];
    assign p_wdata = slot_data[pick_idx][31:0];

    always_comb begin
        p_misaligned = 1'b0;
        p_be         = 4'hF;
        case (p_width)
            2'd0: p_be = 4'b0001 << p_addr[1:0];
            2'd1: begin
                p_be         = 4'b0011 << p_addr[1:0];
                p_misaligned = p_addr[0];
            end
            default: p_misaligned = (p_addr[1:0] != 2'b00);
        endcase
    end

    // Response word produced on the SRAM ack; writes return zero data.
    logic [31:0] ack_rdata;
    logic [33:0] ack_word;

    assign ack_rdata = mem_we ? 32'd0 : (mem_rdata >> {cur_shift, 3'b000});
    assign ack_word  = {(mem_err ? RESP_ERR : RESP_OK), ack_rdata};

    function automatic logic [FW-1:0] make_flit(input logic [NW-1:0] dest,
                                                input logic [PIW-1:0] pid,
                                                input logic [1:0] seq,
                                                input logic [16:0] payload);
        return {1'b1, NW'(NODE_ID), dest, pid, seq, payload};
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_src   <= '0;
            cur_pid   <= '0;
            cur_shift <= '0;
            resp_lo   <= '0;
            flit_out  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        rr_ptr    <= pick_idx;
                        cur_src   <= pick_idx;
                        cur_pid   <= slot_pid[pick_idx];
                        cur_shift <= p_addr[1:0];
                        if (p_misaligned) begin
                            // Low 17 bits of {RESP_ERR, 32'd0} are zero.
                            resp_lo  <= 17'd0;
                            flit_out <= make_flit(pick_idx, slot_pid[pick_idx], 2'd0,
                                                  {RESP_ERR, 15'd0});
                            state    <= RESP0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= p_cmd;
                            mem_be    <= p_be;
                            mem_addr  <= MEM_AWIDTH'({p_addr[31:2], 2'b00});
                            mem_wdata <= p_wdata << {p_addr[1:0], 3'b000};
                            state     <= MEM;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        resp_lo  <= ack_word[16:0];
                        flit_out <= make_flit(cur_src, cur_pid, 2'd0, ack_word[33:17]);
                        state    <= RESP0;
                    end
                end
                RESP0: begin
                    if (flit_out_ready) begin
                        flit_out <= make_flit(cur_src, cur_pid, 2'd1, resp_lo);
                        state    <= RESP1;
                    end
                end
                RESP1: begin
                    if (flit_out_ready) begin
                        flit_out <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (|slot_complete);

endmodule

// File: doc/mem_node_responder.md
Name: mem_node_responder

Overview:
- Memory-side NoC endpoint; it is the responder for the requests that core routers send.
- Reassembles 4-flit dmem request packets from any source node, then performs the read or write on a local single-port SRAM.
- Returns a 2-flit response packet (resp code plus read data) to the requesting node.
- Sits between a NoC router local port and the shared data memory.

Parameters:
- NODE_ID, 0, this node's ID; placed in the src field of outgoing flits.
- NODE_COUNT, 9, number of NoC nodes; NW = $clog2(NODE_COUNT).
- PACKET_ID_WIDTH, 5, width of the packet ID field; echoed unchanged.
- MEM_AWIDTH, 32, SRAM byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flit_in  in  FW  incoming flit; FW = 1+2*NW+17+PACKET_ID_WIDTH+2
- flit_in_ready  out  1  flit_in is consumed when flit_in[FW-1] & flit_in_ready
- flit_out  out  FW  outgoing flit; bit FW-1 is valid
- flit_out_ready  in  1  router accepts flit_out this cycle
- mem_req  out  1  SRAM request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  MEM_AWIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  request completes this cycle
- mem_rdata  in  32  valid with mem_ack on reads
- mem_err  in  1  valid with mem_ack
- drop_count  out  8  saturating count of discarded flits
- busy  out  1  FSM not IDLE, or any slot complete

Behaviour:
- Flit fields, MSB to LSB: valid[1], src[NW], dest[NW], packet_id[PIW], seq[2], payload[17].
- Request packet: 68 bits {cmd(1, 1=write), width(2: 0=byte, 1=half, 2=word), addr(32), wdata(32), pad(1)}.
  - Flit seq k carries bits [67-17k : 51-17k].
- Response packet: 34 bits {resp(2), rdata(32)} in 2 flits (seq 0, 1), same slicing.
  - resp: 2'b01 = OK, 2'b10 = ERROR.
- Assembly:
  - One 68-bit slot per source, each with expected-seq counter (0..3), packet_id register and complete flag.
  - A flit is accepted only if the slot for its src is not complete.
  - flit_in_ready = !slot[src].complete (combinational on flit_in src).
  - Flits with seq != expected: discard the whole slot, reset expected to 0, increment drop_count (saturates at 255).
  - The exception is seq == 0, which always restarts the slot.
  - Flits whose dest != NODE_ID are discarded and counted.
  - Accepting seq 3 sets complete in the next cycle.
- Arbitration: round-robin over complete slots, starting after the last served source.
- FSM states and transitions:
  - IDLE: pick a slot. If the address is misaligned (half with addr[0]; word with addr[1:0] != 0), go to RESP0 with resp = ERROR and rdata = 0, with no memory access. Otherwise go to MEM.
  - MEM: hold mem_req and all mem_* stable until mem_ack. On ack, latch rdata >> 8*addr[1:0] (0 for writes) and resp = mem_err ? ERROR : OK, then go to RESP0.
  - RESP0: drive flit0 until flit_out_ready, then RESP1.
  - RESP1: drive flit1 until flit_out_ready, then clear slot complete and go to IDLE.
- mem_be: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'hF.
- mem_wdata = wdata << 8*addr[1:0].
- Outgoing flit: valid = 1, src = NODE_ID, dest = request src, packet_id echoed.
  - flit_out valid is 0 outside RESP0/RESP1; flit_out holds stable while not ready.
- A slot under service stays complete, so new flits from that source are backpressured. Other sources continue assembling concurrently.
- Latency:
  - Tail flit accepted in cycle T: mem_req no earlier than T+2 (T+1 complete, T+2 MEM).
  - mem_ack in cycle M: flit0 valid at M+1.
  - Misaligned: flit0 at T+2.
- Reset: all slots cleared, FSM IDLE, round-robin pointer 0, drop_count 0.
  - Outputs at reset: flit_out = 0, mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, busy = 0.
  - flit_in_ready = 1 (all slots empty).
  - Reset mid-MEM abandons the access; a late mem_ack is ignored.

Test Plan:
- Word write from src 2, pid 7, addr 0x100, data 0xDEADBEEF, 1-cycle ack -> one SRAM write: mem_addr 0x100, be 4'hF, wdata 0xDEADBEEF. Response: dest 2, pid 7, resp 01, rdata 0.
- Byte read at 0x103, SRAM word 0xAABBCCDD -> SRAM read at 0x100 with be 4'b1000. Response rdata 0x000000AA, resp 01.
- Half read at 0x101 -> no mem_req; response resp 10, rdata 0, flit0 two cycles after tail.
- Interleaved flits from src 1 and src 4, both complete the same cycle -> src 1 served first (pointer 0), then src 4. Two correct response packets.
- Src 3 sends seq 0, 1, 3 -> drop_count 1 and no access. A following clean 4-flit packet is served normally.
- flit_out_ready low 5 cycles in RESP0 -> flit_out stable. Src of the in-service slot sees flit_in_ready = 0; a new packet from another source is accepted meanwhile.
